// File: rtl/qcu_phys_pkg.sv
// qcu_phys_pkg: shared fixed-point type and pulse scheduler state encoding
package qcu_phys_pkg;
  typedef logic signed [15:0] fixed_t;
  localparam fixed_t FIXED_ONE = 16'h4000;
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, MEASURE} sched_state_e;
endpackage

// File: rtl/qubit_pulse_scheduler_if.sv
// qubit_pulse_scheduler_if: requester pulse-request and measurement-response bus
interface qubit_pulse_scheduler_if #(parameter int NUM_REQ = 4, parameter int DUR_W = 8);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0][15:0] req_strength;
  logic [NUM_REQ-1:0][DUR_W-1:0] req_cycles;
  logic rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic rsp_meas;
  modport master(output req_valid, req_strength, req_cycles, input req_ready, rsp_valid, rsp_id, rsp_meas);
  modport slave(input req_valid, req_strength, req_cycles, output req_ready, rsp_valid, rsp_id, rsp_meas);
endinterface

// File: rtl/qubit_pulse_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] idx;
  // descending scan so the requester closest to ptr is the last (winning) match
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) gnt_idx = idx;
    end
    if (en && |req) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/qubit_pulse_scheduler.sv
// qubit_pulse_scheduler: shares one hamiltonian engine among requesters (pulse, settle, measure)
module qubit_pulse_scheduler
  import qcu_phys_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int DUR_W = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   run,
  qubit_pulse_scheduler_if.slave bus,
  output logic   eng_enable,
  output logic   eng_apply_pulse,
  output fixed_t eng_pulse_strength,
  input  logic   eng_measurement,
  output logic   busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = DUR_W > SW ? DUR_W : SW;
  localparam logic [CW-1:0] SETTLE_N = CW'(SETTLE_CYCLES);
  sched_state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt_idx;
  fixed_t str_q, str_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rsp_valid_q, rsp_valid_d, rsp_meas_q, rsp_meas_d;
  logic [NUM_REQ-1:0] gnt;
  logic [DUR_W-1:0] win_cycles;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(bus.req_valid), .ptr(ptr_q), .en(state_q == IDLE), .gnt(gnt), .gnt_idx(gnt_idx)
  );
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_meas = rsp_meas_q;
  assign win_cycles = bus.req_cycles[gnt_idx];
  assign busy = state_q != IDLE;
  assign eng_apply_pulse = state_q == PULSE;
  assign eng_pulse_strength = state_q == PULSE ? str_q : '0;
  assign eng_enable = state_q == PULSE || state_q == SETTLE || run;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    str_d = str_q;
    cnt_d = cnt_q;
    id_d = id_q;
    rsp_valid_d = 1'b0;
    rsp_id_d = rsp_id_q;
    rsp_meas_d = rsp_meas_q;
    case (state_q)
      IDLE: if (|gnt) begin
        str_d = bus.req_strength[gnt_idx];
        id_d = gnt_idx;
        ptr_d = gnt_idx == ID_W'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        cnt_d = win_cycles != '0 ? CW'(win_cycles) : SETTLE_N;
        state_d = win_cycles != '0 ? PULSE : SETTLE;
      end
      PULSE: begin
        cnt_d = cnt_q == CW'(1) ? SETTLE_N : cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? SETTLE : PULSE;
      end
      SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? MEASURE : SETTLE;
      end
      MEASURE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d = id_q;
        rsp_meas_d = eng_measurement;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      str_q <= '0;
      cnt_q <= '0;
      id_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_meas_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      str_q <= str_d;
      cnt_q <= cnt_d;
      id_q <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_meas_q <= rsp_meas_d;
    end
  end
endmodule

// File: tb/tb_qubit_pulse_scheduler.sv
// tb_qubit_pulse_scheduler: directed scenarios with hand-computed timing and grant order
module tb_qubit_pulse_scheduler;
  import qcu_phys_pkg::*;
  logic clk = 1'b0;
  logic rst, run, eng_enable, eng_apply_pulse, eng_measurement, busy;
  fixed_t eng_pulse_strength;
  int n_cmp = 0;
  int n_bad = 0;
  qubit_pulse_scheduler_if #(.NUM_REQ(4), .DUR_W(8)) bus ();
  qubit_pulse_scheduler #(.NUM_REQ(4), .SETTLE_CYCLES(4), .DUR_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus),
    .eng_enable(eng_enable), .eng_apply_pulse(eng_apply_pulse),
    .eng_pulse_strength(eng_pulse_strength), .eng_measurement(eng_measurement), .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.req_valid = '0;
    eng_measurement = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    run = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_cycles = {8'd3, 8'd3, 8'd3, 8'd3};
    tick;
    tick;
    do_reset;
    n_cmp++;
    if ({busy, bus.rsp_valid, bus.rsp_meas, eng_apply_pulse} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, bus.rsp_valid, bus.rsp_meas, eng_apply_pulse});
    end
    n_cmp++;
    if (bus.rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
    n_cmp++;
    if (eng_pulse_strength !== 16'h0000) begin n_bad++; $display("FAIL reset_strength: got %h expected 0000", eng_pulse_strength); end
    n_cmp++;
    if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    n_cmp++;
    if (eng_enable !== 1'b1) begin n_bad++; $display("FAIL reset_enable_run: got %b expected 1", eng_enable); end
  endtask

  task automatic test_single;
    int ap, en, rsp_at, nrsp, bad_str;
    logic [1:0] id;
    ap = 0; en = 0; rsp_at = -1; nrsp = 0; bad_str = 0; id = '1;
    do_reset;
    run = 1'b0;
    bus.req_strength[0] = 16'h0100;
    bus.req_cycles[0] = 8'd5;
    bus.req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
    tick;
    bus.req_valid = '0;
    for (int k = 1; k <= 14; k++) begin
      if (eng_apply_pulse) begin ap++; if (eng_pulse_strength !== 16'h0100) bad_str++; end
      else if (eng_pulse_strength !== 16'h0000) bad_str++;
      if (eng_enable) en++;
      if (bus.rsp_valid) begin nrsp++; if (rsp_at < 0) begin rsp_at = k; id = bus.rsp_id; end end
      tick;
    end
    n_cmp++;
    if (ap !== 5) begin n_bad++; $display("FAIL single_apply_cycles: got %0d expected 5", ap); end
    n_cmp++;
    if (en !== 9) begin n_bad++; $display("FAIL single_enable_cycles: got %0d expected 9", en); end
    n_cmp++;
    if (bad_str !== 0) begin n_bad++; $display("FAIL single_strength: got %0d bad cycles expected 0", bad_str); end
    n_cmp++;
    if (rsp_at !== 11) begin n_bad++; $display("FAIL single_latency: got %0d expected 11", rsp_at); end
    n_cmp++;
    if (nrsp !== 1) begin n_bad++; $display("FAIL single_rsp_count: got %0d expected 1", nrsp); end
    n_cmp++;
    if (id !== 2'd0) begin n_bad++; $display("FAIL single_rsp_id: got %0d expected 0", id); end
  endtask

  task automatic test_round_robin;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int ng, last, prev_c;
    ng = 0; last = -1; prev_c = -1;
    do_reset;
    run = 1'b1;
    bus.req_cycles = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.req_strength = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    bus.req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      if (c == prev_c + 1 && prev_c >= 0) begin
        n_cmp++;
        if (eng_pulse_strength !== fixed_t'(16'h0100 * (last + 1))) begin
          n_bad++; $display("FAIL rr_strength: got %h expected %h", eng_pulse_strength, 16'h0100 * (last + 1));
        end
      end
      if (bus.req_ready != 4'b0000) begin
        n_cmp++;
        if (bus.req_ready !== (4'b0001 << exp_seq[ng])) begin
          n_bad++; $display("FAIL rr_grant%0d: got %b expected %b", ng, bus.req_ready, 4'b0001 << exp_seq[ng]);
        end
        n_cmp++;
        if (bus.rsp_valid !== (ng > 0)) begin n_bad++; $display("FAIL rr_rsp_overlap%0d: got %b expected %b", ng, bus.rsp_valid, ng > 0); end
        if (ng > 0) begin
          n_cmp++;
          if (int'(bus.rsp_id) !== last) begin n_bad++; $display("FAIL rr_rsp_id%0d: got %0d expected %0d", ng, bus.rsp_id, last); end
          n_cmp++;
          if (c - prev_c !== 7) begin n_bad++; $display("FAIL rr_period%0d: got %0d expected 7", ng, c - prev_c); end
        end
        last = exp_seq[ng];
        prev_c = c;
        ng++;
      end
      tick;
    end
    n_cmp++;
    if (ng !== 5) begin n_bad++; $display("FAIL rr_grant_count: got %0d expected 5", ng); end
    bus.req_valid = '0;
  endtask

  task automatic test_zero_duration;
    int ap, rsp_at;
    logic [1:0] id;
    ap = 0; rsp_at = -1; id = '0;
    do_reset;
    run = 1'b1;
    bus.req_cycles[2] = 8'd0;
    bus.req_strength[2] = 16'h1234;
    bus.req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL zero_ready: got %b expected 0100", bus.req_ready); end
    tick;
    bus.req_valid = '0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy: got %b expected 1", busy); end
    for (int k = 1; k <= 10; k++) begin
      if (eng_apply_pulse) ap++;
      if (bus.rsp_valid && rsp_at < 0) begin rsp_at = k; id = bus.rsp_id; end
      tick;
    end
    n_cmp++;
    if (ap !== 0) begin n_bad++; $display("FAIL zero_apply_cycles: got %0d expected 0", ap); end
    n_cmp++;
    if (rsp_at !== 6) begin n_bad++; $display("FAIL zero_latency: got %0d expected 6", rsp_at); end
    n_cmp++;
    if (id !== 2'd2) begin n_bad++; $display("FAIL zero_rsp_id: got %0d expected 2", id); end
  endtask

  task automatic test_run_gating;
    int en;
    logic en_meas;
    en = 0; en_meas = 1'bx;
    do_reset;
    run = 1'b0;
    #1;
    n_cmp++;
    if (eng_enable !== 1'b0) begin n_bad++; $display("FAIL gate_idle_off: got %b expected 0", eng_enable); end
    run = 1'b1;
    #1;
    n_cmp++;
    if (eng_enable !== 1'b1) begin n_bad++; $display("FAIL gate_idle_on: got %b expected 1", eng_enable); end
    run = 1'b0;
    bus.req_cycles[1] = 8'd2;
    bus.req_valid = 4'b0010;
    #1;
    tick;
    bus.req_valid = '0;
    for (int k = 1; k <= 9; k++) begin
      if (eng_enable) en++;
      if (k == 7) en_meas = eng_enable;
      tick;
    end
    n_cmp++;
    if (en !== 6) begin n_bad++; $display("FAIL gate_enable_cycles: got %0d expected 6", en); end
    n_cmp++;
    if (en_meas !== 1'b0) begin n_bad++; $display("FAIL gate_measure_enable: got %b expected 0", en_meas); end
  endtask

  task automatic test_measurement;
    int rsp_at;
    logic meas;
    logic [1:0] id;
    for (int p = 0; p < 2; p++) begin
      rsp_at = -1; meas = 1'bx; id = '0;
      do_reset;
      run = 1'b1;
      bus.req_cycles[3] = 8'd3;
      bus.req_valid = 4'b1000;
      #1;
      tick;
      bus.req_valid = '0;
      for (int k = 1; k <= 12; k++) begin
        eng_measurement = p == 0 ? (k == 8) : (k == 7 || k == 9);
        if (bus.rsp_valid && rsp_at < 0) begin rsp_at = k; meas = bus.rsp_meas; id = bus.rsp_id; end
        tick;
      end
      eng_measurement = 1'b0;
      n_cmp++;
      if (rsp_at !== 9) begin n_bad++; $display("FAIL meas_latency%0d: got %0d expected 9", p, rsp_at); end
      n_cmp++;
      if (meas !== (p == 0)) begin n_bad++; $display("FAIL meas_value%0d: got %b expected %b", p, meas, p == 0); end
      n_cmp++;
      if (id !== 2'd3) begin n_bad++; $display("FAIL meas_rsp_id%0d: got %0d expected 3", p, id); end
    end
  endtask

  task automatic test_reset_mid_pulse;
    int nrsp;
    nrsp = 0;
    do_reset;
    run = 1'b1;
    bus.req_cycles[1] = 8'd6;
    bus.req_valid = 4'b0010;
    #1;
    tick;
    bus.req_valid = '0;
    tick;
    tick;
    n_cmp++;
    if (eng_apply_pulse !== 1'b1) begin n_bad++; $display("FAIL midrst_in_pulse: got %b expected 1", eng_apply_pulse); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if ({busy, eng_apply_pulse} !== 2'b00) begin n_bad++; $display("FAIL midrst_idle: got %b expected 00", {busy, eng_apply_pulse}); end
    for (int k = 0; k < 12; k++) begin
      if (bus.rsp_valid) nrsp++;
      tick;
    end
    n_cmp++;
    if (nrsp !== 0) begin n_bad++; $display("FAIL midrst_no_rsp: got %0d expected 0", nrsp); end
    bus.req_valid = 4'b0011;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL midrst_ptr: got %b expected 0001", bus.req_ready); end
    bus.req_valid = '0;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b1;
    eng_measurement = 1'b0;
    bus.req_valid = '0;
    bus.req_strength = '0;
    bus.req_cycles = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_zero_duration;
    test_run_gating;
    test_measurement;
    test_reset_mid_pulse;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/qubit_pulse_scheduler.md
Name: qubit_pulse_scheduler

Overview:
Sequences one hamiltonian engine (single-qubit physics model) and shares it between NUM_REQ correction requesters, typically decoder lanes. A round-robin arbiter accepts one pulse request at a time. The FSM then drives enable/apply_pulse/pulse_strength for the requested duration, lets the state settle, samples the measurement and returns it to the winning requester. When idle, free-running evolution (noise) is gated by a global run input.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
SETTLE_CYCLES, 4, free-evolution cycles between pulse end and measurement sample (>=1)
DUR_W, 8, width of per-request pulse duration field
ID_W, $clog2(NUM_REQ), width of response requester id (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
run  in  1  global evolution enable outside pulse/settle
req_valid  in  NUM_REQ  per-requester pulse request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit set
req_strength  in  NUM_REQ*16  per-requester signed 2.14 rotation angle; slice i = bits [16i+15:16i]
req_cycles  in  NUM_REQ*DUR_W  per-requester pulse duration in cycles
eng_enable  out  1  to engine enable
eng_apply_pulse  out  1  to engine apply_pulse
eng_pulse_strength  out  16  to engine pulse_strength
eng_measurement  in  1  from engine measurement (1 = Z<0)
rsp_valid  out  1  one-cycle measurement response strobe
rsp_id  out  ID_W  requester index owning the response
rsp_meas  out  1  sampled measurement
busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, PULSE, SETTLE, MEASURE.
- Reset (rst high at posedge): state=IDLE, rr pointer=0, latched strength/count/id=0, rsp_valid=0, rsp_id=0, rsp_meas=0. Reset takes priority mid-operation: an in-flight request is dropped with no response.
- IDLE:
  - req_ready is combinational: one-hot grant to the first req_valid at or after the rr pointer, wrapping modulo NUM_REQ. All zero if no valid, or if not in IDLE.
  - On accept (valid&ready): latch strength, cycles and id; set pointer = winner+1 (wrap NUM_REQ-1 -> 0).
  - Next state: PULSE if cycles != 0, else SETTLE (zero-length pulse is a pure measurement).
- PULSE: eng_enable=1, eng_apply_pulse=1, eng_pulse_strength=latched strength. Count = latched cycles. Stay exactly cycles clock cycles, then go to SETTLE.
- SETTLE: eng_enable=1, apply_pulse=0, strength=0. Stay exactly SETTLE_CYCLES cycles, then go to MEASURE.
- MEASURE: one cycle. eng_enable=run. Sample eng_measurement into rsp_meas and latched id into rsp_id, then go to IDLE. rsp_valid=1 for exactly the following cycle; a new request may be accepted in that same cycle.
- In IDLE and MEASURE: eng_enable=run, apply_pulse=0, strength=0.
- In PULSE and SETTLE: run is ignored; the sequence always completes.
- Latency: accept at cycle T -> rsp_valid at T+N+SETTLE_CYCLES+2 (N = cycles). Throughput: one request per N+SETTLE_CYCLES+2 cycles.
- Requester inputs may change after acceptance without effect. A requester that drops valid before being granted is simply skipped.
- All engine-facing outputs are combinational from state and latched registers only, never from req_* inputs.

Decomposition:
- Package qcu_phys_pkg:
  - fixed_t (signed 16-bit 2.14), FIXED_ONE=16'h4000
  - sched_state_e enum {IDLE, PULSE, SETTLE, MEASURE}
- One sub-module rr_arbiter (parameter N): inputs req[N], ptr, en; outputs one-hot gnt and encoded gnt_idx. Combinational; the pointer register lives in the scheduler.

Test Plan:
- Single request: req0 strength 16'h0100, cycles 5, SETTLE_CYCLES=4 -> ready0 same cycle. apply_pulse high exactly 5 cycles with strength 16'h0100. enable high 9 cycles. rsp_valid at T+11 with rsp_id=0.
- Round robin: all 4 valid continuously, cycles 1 each -> grants in order 0,1,2,3,0. Each new grant coincides with the previous rsp_valid cycle.
- Zero duration: req2 cycles 0 -> no apply_pulse cycle; rsp_valid at T+6 with rsp_id=2.
- Run gating: run=0 in IDLE -> eng_enable=0. A request accepted with run=0 -> enable still high through PULSE and SETTLE.
- Measurement capture: engine model forced to measurement=1 during MEASURE and 0 otherwise -> rsp_meas=1.
- Reset mid-PULSE: rst asserted on the 3rd pulse cycle -> next cycle IDLE, apply_pulse=0, no rsp_valid, pointer 0 (req0 wins the next arbitration over req1).
